// File: rtl/vdp_sprite_meta_uploader_if.sv
// Host register-write channel plus the sprite metadata write port driven by the uploader.
// The uploader takes the slave side; the host decode / testbench takes the master side.
interface vdp_sprite_meta_uploader_if;
    logic        host_valid;
    logic        host_ready;
    logic [1:0]  host_reg;
    logic [15:0] host_data;
    logic [7:0]  meta_address;
    logic [15:0] meta_write_data;
    logic [2:0]  meta_block_select;
    logic        meta_we;

    modport master (
        output host_valid,
        output host_reg,
        output host_data,
        input  host_ready,
        input  meta_address,
        input  meta_write_data,
        input  meta_block_select,
        input  meta_we
    );

    modport slave (
        input  host_valid,
        input  host_reg,
        input  host_data,
        output host_ready,
        output meta_address,
        output meta_write_data,
        output meta_block_select,
        output meta_we
    );
endinterface

// File: rtl/vdp_sprite_meta_uploader.sv
// Buffered host front end for the sprite metadata RAMs: SETUP/STEP/DATA register writes are queued
// and drained one word per cycle. Define VDP_SPRITE_META_VBLANK_GATE_EN to drain only while vblank is high.
module vdp_sprite_meta_uploader #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset_n,
    vdp_sprite_meta_uploader_if.slave        bus,
    input  logic                             vblank,
    output logic [4:0]                       fifo_level,
    output logic                             busy
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REG_SETUP = 2'd0,
        REG_DATA  = 2'd1,
        REG_STEP  = 2'd2,
        REG_RSVD  = 2'd3
    } host_reg_e;

    typedef struct packed {
        logic [7:0]  addr;
        logic [2:0]  sel;
        logic [15:0] data;
    } entry_t;

    entry_t            fifo_mem_q [FIFO_DEPTH];
    entry_t            push_entry;
    entry_t            head_entry;

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]        level_q, level_d;
    logic [7:0]        addr_q, addr_d;
    logic [2:0]        sel_q, sel_d;
    logic [7:0]        step_q, step_d;

    logic [7:0]        meta_address_q, meta_address_d;
    logic [15:0]       meta_write_data_q, meta_write_data_d;
    logic [2:0]        meta_block_select_q, meta_block_select_d;
    logic              meta_we_q, meta_we_d;

    logic              drain_ok;
    logic              fifo_full;
    logic              fifo_empty;
    logic              host_fire;
    logic              push;
    logic              pop;

`ifdef VDP_SPRITE_META_VBLANK_GATE_EN
    // Hold queued entries during active display so metadata never tears mid-frame.
    assign drain_ok = vblank;
`else
    logic unused_vblank;
    assign unused_vblank = vblank;
    assign drain_ok      = 1'b1;
`endif

    assign fifo_full  = (level_q == 5'(FIFO_DEPTH));
    assign fifo_empty = (level_q == 5'd0);

    // Ready ignores host_reg so SETUP/STEP can never overtake a stalled DATA write.
    assign bus.host_ready = !fifo_full;
    assign host_fire      = bus.host_valid && !fifo_full;
    assign push           = host_fire && (host_reg_e'(bus.host_reg) == REG_DATA);
    assign pop            = !fifo_empty && drain_ok;

    assign push_entry = '{addr: addr_q, sel: sel_q, data: bus.host_data};
    assign head_entry = fifo_mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every _d starts from its held value so no branch below can infer a latch.
        wr_ptr_d            = wr_ptr_q;
        rd_ptr_d            = rd_ptr_q;
        addr_d              = addr_q;
        sel_d               = sel_q;
        step_d              = step_q;
        meta_address_d      = meta_address_q;
        meta_write_data_d   = meta_write_data_q;
        meta_block_select_d = meta_block_select_q;
        meta_we_d           = 1'b0;

        if (host_fire) begin
            case (host_reg_e'(bus.host_reg))
                REG_SETUP: begin
                    addr_d = bus.host_data[7:0];
                    sel_d  = bus.host_data[10:8];
                end
                REG_STEP: step_d = bus.host_data[7:0];
                REG_DATA: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    addr_d   = addr_q + step_q;
                end
                default: ;
            endcase
        end

        if (pop) begin
            rd_ptr_d            = rd_ptr_q + PTR_W'(1);
            meta_address_d      = head_entry.addr;
            meta_write_data_d   = head_entry.data;
            meta_block_select_d = head_entry.sel;
            meta_we_d           = 1'b1;
        end

        level_d = level_q + 5'(push) - 5'(pop);
    end

    // NOTE: the queue storage has no reset; the pointers and level alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q            <= '0;
            rd_ptr_q            <= '0;
            level_q             <= 5'd0;
            addr_q              <= 8'h00;
            sel_q               <= 3'b000;
            step_q              <= 8'h01;
            meta_address_q      <= 8'h00;
            meta_write_data_q   <= 16'h0000;
            meta_block_select_q <= 3'b000;
            meta_we_q           <= 1'b0;
        end else begin
            wr_ptr_q            <= wr_ptr_d;
            rd_ptr_q            <= rd_ptr_d;
            level_q             <= level_d;
            addr_q              <= addr_d;
            sel_q               <= sel_d;
            step_q              <= step_d;
            meta_address_q      <= meta_address_d;
            meta_write_data_q   <= meta_write_data_d;
            meta_block_select_q <= meta_block_select_d;
            meta_we_q           <= meta_we_d;
        end
    end

    assign bus.meta_address      = meta_address_q;
    assign bus.meta_write_data   = meta_write_data_q;
    assign bus.meta_block_select = meta_block_select_q;
    assign bus.meta_we           = meta_we_q;

    assign fifo_level = level_q;
    assign busy       = !fifo_empty || meta_we_q;
endmodule

// File: tb/tb_vdp_sprite_meta_uploader.sv
// Self-checking bench for vdp_sprite_meta_uploader: directed scenarios plus random traffic against
// a queue-based reference model. Full-FIFO scenario needs VDP_SPRITE_META_VBLANK_GATE_EN.
module tb_vdp_sprite_meta_uploader;
    localparam int DEPTH = 8;

    typedef struct {
        logic [7:0]  addr;
        logic [2:0]  sel;
        logic [15:0] data;
    } wr_t;

    logic       clk;
    logic       reset_n;
    logic       vblank;
    logic [4:0] fifo_level;
    logic       busy;

    vdp_sprite_meta_uploader_if bus ();

    vdp_sprite_meta_uploader #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bus        (bus.slave),
        .vblank     (vblank),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: host registers, queue of pending writes, last written word.
    wr_t        m_q [$];
    wr_t        obs [$];
    wr_t        m_out;
    logic [7:0] m_addr;
    logic [7:0] m_step;
    logic [2:0] m_sel;
    bit         m_we;
    int         m_pulses;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic bit drain_ok(input bit vb);
`ifdef VDP_SPRITE_META_VBLANK_GATE_EN
        return vb;
`else
        return 1'b1 | vb;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_addr = 8'h00;
        m_sel  = 3'b000;
        m_step = 8'h01;
        m_out  = '{8'h00, 3'b000, 16'h0000};
        m_we   = 1'b0;
    endtask

    // One clock: drive inputs just after a falling edge, advance the model at the rising
    // edge, compare every output at the next falling edge.
    task automatic cycle(input bit v, input logic [1:0] r, input logic [15:0] d,
                         input bit vb, output bit acc);
        bit pop;
        bus.host_valid = v;
        bus.host_reg   = r;
        bus.host_data  = d;
        vblank         = vb;
        #1;
        check("host_ready", bus.host_ready, m_q.size() < DEPTH);
        acc = v && (m_q.size() < DEPTH);
        pop = (m_q.size() > 0) && drain_ok(vb);
        @(posedge clk);
        m_we = pop;
        if (pop) begin
            m_out = m_q.pop_front();
            m_pulses++;
        end
        if (acc) begin
            case (r)
                2'd0: begin
                    m_addr = d[7:0];
                    m_sel  = d[10:8];
                end
                2'd1: begin
                    m_q.push_back('{m_addr, m_sel, d});
                    m_addr = m_addr + m_step;
                end
                2'd2: m_step = d[7:0];
                default: ;
            endcase
        end
        @(negedge clk);
        check("meta_we", bus.meta_we, m_we);
        check("meta_address", bus.meta_address, m_out.addr);
        check("meta_write_data", bus.meta_write_data, m_out.data);
        check("meta_block_select", bus.meta_block_select, m_out.sel);
        check("fifo_level", fifo_level, m_q.size());
        check("busy", busy, (m_q.size() > 0) || m_we);
        if (bus.meta_we === 1'b1)
            obs.push_back('{bus.meta_address, bus.meta_block_select, bus.meta_write_data});
        bus.host_valid = 1'b0;
    endtask

    task automatic write(input logic [1:0] r, input logic [15:0] d, input bit vb);
        bit acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) cycle(1'b1, r, d, vb, acc);
        check("write_accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n, input bit vb);
        bit acc;
        for (int i = 0; i < n; i++) cycle(1'b0, 2'd0, 16'h0000, vb, acc);
    endtask

    task automatic check_obs(input string tag, input int idx, input logic [7:0] a,
                             input logic [2:0] s, input logic [15:0] d);
        check({tag, "_addr"}, obs[idx].addr, a);
        check({tag, "_sel"}, obs[idx].sel, s);
        check({tag, "_data"}, obs[idx].data, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n_sent;
        bus.host_valid = 1'b0;
        bus.host_reg   = 2'd0;
        bus.host_data  = 16'h0000;
        vblank         = 1'b0;
        reset_n        = 1'b0;
        m_pulses       = 0;
        model_reset();
        #3;
        check("rst_meta_we", bus.meta_we, 1'b0);
        check("rst_meta_address", bus.meta_address, 8'h00);
        check("rst_fifo_level", fifo_level, 5'd0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Auto-increment with step 1 after reset.
        obs.delete();
        write(2'd0, 16'h0302, 1'b1);
        write(2'd1, 16'hAAAA, 1'b1);
        write(2'd1, 16'hBBBB, 1'b1);
        idle(4, 1'b1);
        check("autoinc_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check_obs("autoinc0", 0, 8'h02, 3'b011, 16'hAAAA);
            check_obs("autoinc1", 1, 8'h03, 3'b011, 16'hBBBB);
        end

        // Step 0x10 with address wrap past 0xFF.
        obs.delete();
        write(2'd2, 16'h0010, 1'b1);
        write(2'd0, 16'h04F8, 1'b1);
        for (int i = 0; i < 3; i++) write(2'd1, 16'(16'hC000 + i), 1'b1);
        idle(5, 1'b1);
        check("wrap_count", obs.size(), 3);
        if (obs.size() == 3) begin
            check_obs("wrap0", 0, 8'hF8, 3'b100, 16'hC000);
            check_obs("wrap1", 1, 8'h08, 3'b100, 16'hC001);
            check_obs("wrap2", 2, 8'h18, 3'b100, 16'hC002);
        end

        // Fill the queue with drain blocked, then release it.
        obs.delete();
        write(2'd2, 16'h0001, 1'b1);
        write(2'd0, 16'h0120, 1'b1);
        idle(2, 1'b1);
        obs.delete();
        for (int i = 0; i < 8; i++) write(2'd1, 16'(16'h0100 + i), 1'b0);
        cycle(1'b1, 2'd1, 16'h0108, 1'b0, acc);
`ifdef VDP_SPRITE_META_VBLANK_GATE_EN
        check("full_ready", bus.host_ready, 1'b0);
        check("full_level", fifo_level, 5'd8);
        check("full_no_we", obs.size(), 0);
`endif
        if (!acc) write(2'd1, 16'h0108, 1'b1);
        idle(12, 1'b1);
        check("full_count", obs.size(), 9);
        if (obs.size() == 9)
            for (int i = 0; i < 9; i++)
                check_obs("full", i, 8'(8'h20 + i), 3'b001, 16'(16'h0100 + i));

        // Simultaneous push and pop: level never exceeds one.
        obs.delete();
        for (int i = 0; i < 20; i++) begin
            write(2'd1, 16'(16'h2000 + i), 1'b1);
            check("pp_level_le1", fifo_level <= 5'd1, 1'b1);
        end
        idle(4, 1'b1);
        check("pp_count", obs.size(), 20);

        // SETUP between queued DATA only affects later writes; sel 0 still pulses.
        obs.delete();
        write(2'd0, 16'h0010, 1'b0);
        write(2'd1, 16'h1111, 1'b0);
        write(2'd0, 16'h0080, 1'b0);
        write(2'd1, 16'h2222, 1'b0);
        idle(5, 1'b1);
        check("order_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check_obs("order0", 0, 8'h10, 3'b000, 16'h1111);
            check_obs("order1", 1, 8'h80, 3'b000, 16'h2222);
        end

        // Random traffic, vblank mostly high.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 16'($urandom),
                  $urandom_range(0, 3) != 0, acc);
        for (int i = 0; i < 20 && (m_q.size() > 0 || m_we); i++) idle(1, 1'b1);

        // Reset during the second pulse of a five-entry burst.
        m_pulses = 0;
        n_sent   = 0;
        for (int i = 0; i < 30 && m_pulses < 2; i++) begin
            cycle(n_sent < 5, 2'd1, 16'(16'h5000 + n_sent), n_sent >= 5, acc);
            if (acc) n_sent++;
        end
        check("rst_mid_pulses", m_pulses, 2);
        check("rst_mid_we_before", bus.meta_we, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_meta_we", bus.meta_we, 1'b0);
        check("rst_mid_meta_address", bus.meta_address, 8'h00);
        check("rst_mid_meta_data", bus.meta_write_data, 16'h0000);
        check("rst_mid_meta_sel", bus.meta_block_select, 3'b000);
        check("rst_mid_fifo_level", fifo_level, 5'd0);
        check("rst_mid_busy", busy, 1'b0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        obs.delete();
        idle(8, 1'b1);
        check("rst_mid_no_pulses", obs.size(), 0);

        // Step register is back to 1 after reset.
        write(2'd0, 16'h07FE, 1'b1);
        write(2'd1, 16'hD00D, 1'b1);
        write(2'd1, 16'hF00D, 1'b1);
        idle(4, 1'b1);
        check("rst_step_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check_obs("rst_step0", 0, 8'hFE, 3'b111, 16'hD00D);
            check_obs("rst_step1", 1, 8'hFF, 3'b111, 16'hF00D);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vdp_sprite_meta_uploader.md
# vdp_sprite_meta_uploader

Buffered host-side front end that feeds the sprite metadata write port of the sprite core (`meta_address`, `meta_write_data`, `meta_block_select`, `meta_we`). The CPU issues register writes: an address/block-select setup, an auto-increment step, and data words. Data words are queued with their target address in an 8-entry FIFO and drained into the sprite metadata RAMs at one word per cycle. It sits directly upstream of the sprite core, between the VDP host register decode and the x/y/g metadata blocks.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: number of queued writes; must be a power of two, 2..16.

Ports:
- `clk` in 1: single clock domain. All ports are sampled and driven on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `host_valid` in 1: host register write request.
- `host_ready` out 1: the write is accepted on an edge where `host_valid && host_ready`.
- `host_reg` in 2: register select.
  - 0 = SETUP: `host_data[7:0]` is the address and `host_data[10:8]` is the block select.
  - 1 = DATA.
  - 2 = STEP: `host_data[7:0]`.
  - 3 = reserved.
- `host_data` in 16: write data.
- `vblank` in 1: drain-permit input. It is used only when the gate feature is compiled in.
- `meta_address` out 8: sprite metadata address.
- `meta_write_data` out 16: sprite metadata word.
- `meta_block_select` out 3: one-hot-or-multi block mask. Bit 0 = x, bit 1 = y, bit 2 = g.
- `meta_we` out 1: write strobe, one cycle per word.
- `fifo_level` out 5: number of occupied entries, 0..`FIFO_DEPTH`.
- `busy` out 1: high when the FIFO is non-empty or `meta_we` is high.

## Operation
Registers:
- `addr_r` is 8 bits, reset 0x00.
- `sel_r` is 3 bits, reset 3'b000.
- `step_r` is 8 bits, reset 0x01.

Host write handling:
- `host_ready = !fifo_full`, regardless of `host_reg`. This keeps accept ordering strict.
- SETUP accepted: `addr_r <= host_data[7:0]` and `sel_r <= host_data[10:8]`. Nothing is pushed.
- STEP accepted: `step_r <= host_data[7:0]`. Step 0 is legal and repeats the same address.
- DATA accepted: push {`addr_r`, `sel_r`, `host_data`} and set `addr_r <= addr_r + step_r`. The addition is modulo 256, so 0xFF + 1 wraps to 0x00.
- Reserved accepted: no effect.
- SETUP or STEP changes affect only later DATA writes. Queued entries keep their own captured address and select.

Drain:
- A pop occurs on any edge where the FIFO is non-empty and `drain_ok` is true.
- On a pop, the output registers load the head entry and `meta_we <= 1`. Otherwise `meta_we <= 0`.
- The other outputs hold their last value when `meta_we` is 0.
- An entry with `sel` = 0 still pops and pulses `meta_we`. No block is written.
- Push and pop on the same edge: `fifo_level` is unchanged. At `FIFO_DEPTH` no push can occur because `host_ready` is 0.

Reset:
- Reset is asynchronous. It clears the FIFO pointers, `fifo_level`, `addr_r`, `sel_r` and `step_r` (to 1), and all outputs: `meta_*` = 0, `meta_we` = 0, `busy` = 0.
- `host_ready` is 1 once reset is deasserted.
- Reset in mid-drain discards queued entries. No partial `meta_we` is produced.

## Timing
- DATA accepted at edge E into an empty FIFO with `drain_ok` high: the entry is visible after E, pops at E+1, and `meta_we` is high during the cycle after E+1. Latency is 2 edges.
- Sustained throughput is 1 word per cycle.
- `host_ready` falls in the cycle after the accept that fills the FIFO. It rises in the cycle after the pop that frees an entry.
- `fifo_level` and `busy` are registered or derived from registered state. They update in the cycle after the edge that changes them.
- `drain_ok` is sampled at the pop edge. A `vblank` drop blocks pops from the next edge on. An entry already loaded into the output registers still completes its one-cycle `meta_we`.

## Configuration
- `VDP_SPRITE_META_VBLANK_GATE_EN` defined: `drain_ok = vblank`. Entries stay queued during active display, which avoids mid-frame metadata tearing.
- Macro undefined: `drain_ok = 1`. The `vblank` input is ignored and the FIFO drains immediately.

## Test plan
- Auto-increment: SETUP 0x0302 (addr 0x02, sel x|y), then DATA 0xAAAA, 0xBBBB.
  - Expected: `meta_we` pulses on 2 consecutive cycles.
  - Addresses 0x02 then 0x03, select 3'b011, data 0xAAAA then 0xBBBB.
  - First pulse 2 edges after the first accept.
- Wrap and step: STEP 0x10, SETUP 0x04F8, then 3 DATA writes.
  - Expected: addresses 0xF8, 0x08, 0x18, select 3'b100.
- Full FIFO: with the gate macro defined and `vblank` = 0, issue 9 DATA writes back to back.
  - Expected: 8 are accepted, `host_ready` = 0, `fifo_level` = 8, no `meta_we`.
  - Raise `vblank`: 8 consecutive `meta_we` pulses in order, then the 9th write is accepted and drained.
- Push and pop together: with a continuous drain, DATA every cycle for 20 cycles.
  - Expected: `fifo_level` stays at 1 or less, and 20 pulses arrive in order.
- Setup ordering: DATA 0x1111 at addr 0x10, then SETUP addr 0x80, then DATA 0x2222, all while the drain is blocked.
  - Expected on drain: 0x1111 written to 0x10, then 0x2222 written to 0x80.
- Reset mid-drain: 5 entries queued, then assert `reset_n` = 0 for 1 cycle during the 2nd pulse.
  - Expected: outputs go to 0 immediately, `fifo_level` = 0, `step_r` = 1, and no further pulses.
